// File: rtl/fetch_decode.sv
// Instruction fetch and decode front end.
// Fetches one byte per instruction from a simple req/ack memory, registers the
// decoded fields at the ack edge and holds them for the executor until consumed.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | one-cycle gap after reset or redirect, no fetch request
// FETCH | imem_req high with imem_addr = pc, waiting for imem_ack
// ISSUE | decoded instruction presented (dec_valid=1), waiting for !stall
// HALT  | halt opcode consumed, waiting for a redirect
module fetch_decode #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  input  logic       stall,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_pc,
  output logic       dec_valid,
  output logic [4:0] opcode,
  output logic [2:0] imm,
  output logic [2:0] register,
  output logic       is_alu_op,
  output logic       is_mem_op,
  output logic       mem_rw,
  output logic [7:0] pc_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [4:0] OP_HALT = 5'b11111;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic       dec_valid_q, dec_valid_d;
  logic       load_dec;

  logic [4:0] opcode_q;
  logic [2:0] imm_q;
  logic [2:0] register_q;
  logic       is_alu_op_q;
  logic       is_mem_op_q;
  logic       mem_rw_q;
  logic [7:0] pc_out_q;

  // Control state, program counter and issue flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      dec_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      dec_valid_q <= dec_valid_d;
    end
  end

  // Next-state logic; a redirect overrides whatever the current state would do.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    dec_valid_d = dec_valid_q;
    load_dec    = 1'b0;
    if (redirect_valid) begin
      state_d     = IDLE;
      pc_d        = redirect_pc;
      dec_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (imem_ack) begin
            load_dec    = 1'b1;
            dec_valid_d = 1'b1;
            pc_d        = pc_q + 8'd1;
            state_d     = ISSUE;
          end
        end
        ISSUE: begin
          if (!stall) begin
            dec_valid_d = 1'b0;
            state_d     = (opcode_q == OP_HALT) ? HALT : FETCH;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Decoded fields only move at an accepted ack; redirects leave them alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opcode_q    <= 5'd0;
      imm_q       <= 3'd0;
      register_q  <= 3'd0;
      is_alu_op_q <= 1'b0;
      is_mem_op_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      pc_out_q    <= 8'd0;
    end else if (load_dec) begin
      opcode_q    <= imem_data[7:3];
      imm_q       <= imem_data[2:0];
      register_q  <= imem_data[2:0];
      is_alu_op_q <= (imem_data[7:6] == 2'b00);
      is_mem_op_q <= (imem_data[7:6] == 2'b01);
      mem_rw_q    <= (imem_data[7:6] == 2'b01) & imem_data[3];
      pc_out_q    <= pc_q;
    end
  end

  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc_q;
  assign dec_valid = dec_valid_q;
  assign opcode    = opcode_q;
  assign imm       = imm_q;
  assign register  = register_q;
  assign is_alu_op = is_alu_op_q;
  assign is_mem_op = is_mem_op_q;
  assign mem_rw    = mem_rw_q;
  assign pc_out    = pc_out_q;

endmodule
